// File: rtl/rv_multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback
// over a unified req/ready memory, with a memory-wait timeout and a sticky trap.
module rv_multicycle_ctrl #(
  parameter bit          HAS_BLT      = 1'b1,
  parameter int unsigned WAIT_TIMEOUT = 16,
  parameter int unsigned STATE_W      = 4
) (
  input  logic               clk,
  input  logic               areset,
  input  logic [6:0]         opcode,
  input  logic [2:0]         funct3,
  input  logic               funct7b5,
  input  logic               zero,
  input  logic               sign,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               mem_write,
  output logic               adr_src,
  output logic               ir_write,
  output logic               pc_write,
  output logic               reg_write,
  output logic [1:0]         alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         result_src,
  output logic [1:0]         imm_src,
  output logic [2:0]         alu_control,
  output logic               trap,
  output logic [1:0]         trap_cause,
  output logic [STATE_W-1:0] state
);

  localparam int unsigned CNT_W = (WAIT_TIMEOUT < 2) ? 1 : $clog2(WAIT_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(WAIT_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((WAIT_TIMEOUT == 0) ? 0 : WAIT_TIMEOUT - 1);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] SRC_A_PC    = 2'b00;
  localparam logic [1:0] SRC_A_OLDPC = 2'b01;
  localparam logic [1:0] SRC_A_REG   = 2'b10;
  localparam logic [1:0] SRC_B_REG   = 2'b00;
  localparam logic [1:0] SRC_B_IMM   = 2'b01;
  localparam logic [1:0] SRC_B_FOUR  = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;

  localparam logic [1:0] TC_NONE    = 2'b00;
  localparam logic [1:0] TC_ILLEGAL = 2'b01;
  localparam logic [1:0] TC_TIMEOUT = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXEC_R   = 4'd6,
    S_EXEC_I   = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  state_t           st, st_nxt;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       cause_nxt;
  logic             is_mem_st, timeout_hit;
  logic             req_c, wr_c, irw_c, pcw_c, rgw_c;

  function automatic logic alu_f3_ok(input logic [2:0] f3);
    return (f3 == 3'b000) || (f3 == 3'b010) || (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

  function automatic logic br_f3_ok(input logic [2:0] f3);
    return (f3 == 3'b000) || (HAS_BLT && (f3 == 3'b100));
  endfunction

  function automatic logic [2:0] alu_op(input logic [2:0] f3, input logic is_r, input logic f7b5);
    logic [2:0] op;
    op = ALU_ADD;
    case (f3)
      3'b000:  op = (is_r && f7b5) ? ALU_SUB : ALU_ADD;
      3'b010:  op = ALU_SLT;
      3'b110:  op = ALU_OR;
      3'b111:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  assign is_mem_st   = (st == S_FETCH) || (st == S_MEMREAD) || (st == S_MEMWRITE);
  // Ready in the last allowed wait cycle takes priority over the timeout.
  assign timeout_hit = (WAIT_TIMEOUT != 0) && is_mem_st && !mem_ready && (cnt == CNT_LAST);

  // Next state and combinational control outputs.
  always_comb begin
    st_nxt      = st;
    cause_nxt   = TC_NONE;
    req_c       = 1'b0;
    wr_c        = 1'b0;
    irw_c       = 1'b0;
    pcw_c       = 1'b0;
    rgw_c       = 1'b0;
    adr_src     = 1'b0;
    alu_src_a   = SRC_A_PC;
    alu_src_b   = SRC_B_REG;
    result_src  = RES_ALUOUT;
    imm_src     = IMM_I;
    alu_control = ALU_ADD;
    case (st)
      S_FETCH: begin
        req_c      = 1'b1;
        alu_src_b  = SRC_B_FOUR;
        result_src = RES_ALU;
        if (mem_ready) begin
          irw_c  = 1'b1;
          pcw_c  = 1'b1;
          st_nxt = S_DECODE;
        end else if (timeout_hit) begin
          st_nxt    = S_TRAP;
          cause_nxt = TC_TIMEOUT;
        end
      end
      S_DECODE: begin
        alu_src_a = SRC_A_OLDPC;
        alu_src_b = SRC_B_IMM;
        imm_src   = IMM_B;
        case (opcode)
          OP_LOAD, OP_STORE: st_nxt = S_MEMADR;
          OP_R:              st_nxt = alu_f3_ok(funct3) ? S_EXEC_R : S_TRAP;
          OP_I:              st_nxt = alu_f3_ok(funct3) ? S_EXEC_I : S_TRAP;
          OP_BR:             st_nxt = br_f3_ok(funct3) ? S_BRANCH : S_TRAP;
          OP_JAL:            st_nxt = S_JAL;
          default:           st_nxt = S_TRAP;
        endcase
        if (st_nxt == S_TRAP) cause_nxt = TC_ILLEGAL;
      end
      S_MEMADR: begin
        alu_src_a = SRC_A_REG;
        alu_src_b = SRC_B_IMM;
        imm_src   = (opcode == OP_LOAD) ? IMM_I : IMM_S;
        st_nxt    = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        req_c   = 1'b1;
        adr_src = 1'b1;
        if (mem_ready) begin
          st_nxt = S_MEMWB;
        end else if (timeout_hit) begin
          st_nxt    = S_TRAP;
          cause_nxt = TC_TIMEOUT;
        end
      end
      S_MEMWB: begin
        result_src = RES_RDATA;
        rgw_c      = 1'b1;
        st_nxt     = S_FETCH;
      end
      S_MEMWRITE: begin
        req_c   = 1'b1;
        wr_c    = 1'b1;
        adr_src = 1'b1;
        if (mem_ready) begin
          st_nxt = S_FETCH;
        end else if (timeout_hit) begin
          st_nxt    = S_TRAP;
          cause_nxt = TC_TIMEOUT;
        end
      end
      S_EXEC_R: begin
        alu_src_a   = SRC_A_REG;
        alu_src_b   = SRC_B_REG;
        alu_control = alu_op(funct3, 1'b1, funct7b5);
        st_nxt      = S_ALUWB;
      end
      S_EXEC_I: begin
        alu_src_a   = SRC_A_REG;
        alu_src_b   = SRC_B_IMM;
        imm_src     = IMM_I;
        alu_control = alu_op(funct3, 1'b0, funct7b5);
        st_nxt      = S_ALUWB;
      end
      S_ALUWB: begin
        result_src = RES_ALUOUT;
        rgw_c      = 1'b1;
        st_nxt     = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a   = SRC_A_REG;
        alu_src_b   = SRC_B_REG;
        alu_control = ALU_SUB;
        result_src  = RES_ALUOUT;
        pcw_c       = ((funct3 == 3'b000) && zero) || (HAS_BLT && (funct3 == 3'b100) && sign);
        st_nxt      = S_FETCH;
      end
      S_JAL: begin
        alu_src_a   = SRC_A_OLDPC;
        alu_src_b   = SRC_B_FOUR;
        alu_control = ALU_ADD;
        result_src  = RES_ALUOUT;
        pcw_c       = 1'b1;
        st_nxt      = S_ALUWB;
      end
      S_TRAP:  st_nxt = S_TRAP;
      default: st_nxt = S_FETCH;
    endcase
  end

  // State, wait counter and sticky trap registers.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      st         <= S_FETCH;
      cnt        <= '0;
      trap       <= 1'b0;
      trap_cause <= TC_NONE;
    end else begin
      st <= st_nxt;
      if (st_nxt != st) begin
        cnt <= '0;
      end else if (is_mem_st && !mem_ready && (cnt != CNT_MAX)) begin
        cnt <= cnt + CNT_W'(1);
      end
      if ((st_nxt == S_TRAP) && !trap) begin
        trap       <= 1'b1;
        trap_cause <= cause_nxt;
      end
    end
  end

  assign mem_req   = req_c & ~areset;
  assign mem_write = wr_c  & ~areset;
  assign ir_write  = irw_c & ~areset;
  assign pc_write  = pcw_c & ~areset;
  assign reg_write = rgw_c & ~areset;
  assign state     = STATE_W'(st);

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Randomized bench for rv_multicycle_ctrl: two instances (BLT on / 4-cycle timeout,
// BLT off / 16-cycle timeout) each checked every cycle against an instruction-plan model.
module tb_rv_multicycle_ctrl;

  localparam int NCYC = 3000;

  // Debug state numbering exposed on the state port.
  localparam int FETCH = 0, DECODE = 1, MEMADR = 2, MEMREAD = 3, MEMWB = 4, MEMWRITE = 5;
  localparam int EXEC_R = 6, EXEC_I = 7, ALUWB = 8, BRANCH = 9, JAL = 10, TRAP = 11;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  typedef struct packed {
    logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
    logic [1:0] a, b, res, imm;
    logic [2:0] alu;
    logic       trap;
    logic [1:0] cause;
    logic [3:0] st;
  } ctl_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       areset    [2];
  logic [6:0] opcode    [2];
  logic [2:0] funct3    [2];
  logic       funct7b5  [2];
  logic       zero      [2];
  logic       sign      [2];
  logic       mem_ready [2];

  logic       d0_req, d0_wr, d0_adr, d0_irw, d0_pcw, d0_rgw, d0_trap;
  logic [1:0] d0_a, d0_b, d0_res, d0_imm, d0_cause;
  logic [2:0] d0_alu;
  logic [3:0] d0_st;
  logic       d1_req, d1_wr, d1_adr, d1_irw, d1_pcw, d1_rgw, d1_trap;
  logic [1:0] d1_a, d1_b, d1_res, d1_imm, d1_cause;
  logic [2:0] d1_alu;
  logic [3:0] d1_st;

  rv_multicycle_ctrl #(.HAS_BLT(1'b1), .WAIT_TIMEOUT(4), .STATE_W(4)) dut0 (
    .clk(clk), .areset(areset[0]), .opcode(opcode[0]), .funct3(funct3[0]),
    .funct7b5(funct7b5[0]), .zero(zero[0]), .sign(sign[0]), .mem_ready(mem_ready[0]),
    .mem_req(d0_req), .mem_write(d0_wr), .adr_src(d0_adr), .ir_write(d0_irw),
    .pc_write(d0_pcw), .reg_write(d0_rgw), .alu_src_a(d0_a), .alu_src_b(d0_b),
    .result_src(d0_res), .imm_src(d0_imm), .alu_control(d0_alu), .trap(d0_trap),
    .trap_cause(d0_cause), .state(d0_st)
  );

  rv_multicycle_ctrl #(.HAS_BLT(1'b0), .WAIT_TIMEOUT(16), .STATE_W(4)) dut1 (
    .clk(clk), .areset(areset[1]), .opcode(opcode[1]), .funct3(funct3[1]),
    .funct7b5(funct7b5[1]), .zero(zero[1]), .sign(sign[1]), .mem_ready(mem_ready[1]),
    .mem_req(d1_req), .mem_write(d1_wr), .adr_src(d1_adr), .ir_write(d1_irw),
    .pc_write(d1_pcw), .reg_write(d1_rgw), .alu_src_a(d1_a), .alu_src_b(d1_b),
    .result_src(d1_res), .imm_src(d1_imm), .alu_control(d1_alu), .trap(d1_trap),
    .trap_cause(d1_cause), .state(d1_st)
  );

  logic [23:0] obs0, obs1;
  assign obs0 = {d0_req, d0_wr, d0_adr, d0_irw, d0_pcw, d0_rgw, d0_a, d0_b, d0_res,
                 d0_imm, d0_alu, d0_trap, d0_cause, d0_st};
  assign obs1 = {d1_req, d1_wr, d1_adr, d1_irw, d1_pcw, d1_rgw, d1_a, d1_b, d1_res,
                 d1_imm, d1_alu, d1_trap, d1_cause, d1_st};

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  // Model: current state, cycles waited in a memory state, trap cause, time in trap,
  // and the list of states the decoded instruction still has to walk through.
  int m_st [2], m_wait [2], m_cause [2], m_tc [2], m_pi [2], m_len [2], stuck [2];
  int m_plan [2][3];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s got=%h want=%h", tag, got, want);
  endtask

  function automatic bit has_blt(input int k);
    return k == 0;
  endfunction

  function automatic int tmo(input int k);
    return (k == 0) ? 4 : 16;
  endfunction

  function automatic logic [2:0] alu_of(input logic [2:0] f3, input bit is_r, input logic f7b5);
    case (f3)
      3'b000:  return (is_r && f7b5) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic ctl_t expect_ctl(input int k);
    ctl_t e;
    e       = '0;
    e.st    = 4'(m_st[k]);
    e.trap  = (m_st[k] == TRAP);
    e.cause = 2'(m_cause[k]);
    case (m_st[k])
      FETCH: begin
        e.mem_req  = 1'b1; e.b = 2'b10; e.res = 2'b10;
        e.ir_write = mem_ready[k]; e.pc_write = mem_ready[k];
      end
      DECODE:   begin e.a = 2'b01; e.b = 2'b01; e.imm = 2'b10; end
      MEMADR:   begin e.a = 2'b10; e.b = 2'b01; e.imm = (opcode[k] == OP_STORE) ? 2'b01 : 2'b00; end
      MEMREAD:  begin e.mem_req = 1'b1; e.adr_src = 1'b1; end
      MEMWB:    begin e.res = 2'b01; e.reg_write = 1'b1; end
      MEMWRITE: begin e.mem_req = 1'b1; e.mem_write = 1'b1; e.adr_src = 1'b1; end
      EXEC_R:   begin e.a = 2'b10; e.alu = alu_of(funct3[k], 1'b1, funct7b5[k]); end
      EXEC_I:   begin e.a = 2'b10; e.b = 2'b01; e.alu = alu_of(funct3[k], 1'b0, funct7b5[k]); end
      ALUWB:    e.reg_write = 1'b1;
      BRANCH: begin
        e.a = 2'b10; e.alu = 3'b001;
        e.pc_write = ((funct3[k] == 3'b000) && zero[k]) ||
                     (has_blt(k) && (funct3[k] == 3'b100) && sign[k]);
      end
      JAL:      begin e.a = 2'b01; e.b = 2'b10; e.pc_write = 1'b1; end
      default:  ;
    endcase
    if (areset[k]) begin
      e.mem_req = 1'b0; e.mem_write = 1'b0; e.ir_write = 1'b0;
      e.pc_write = 1'b0; e.reg_write = 1'b0;
    end
    return e;
  endfunction

  function automatic void set_plan(input int k, input int n, input int s0, input int s1, input int s2);
    m_plan[k][0] = s0; m_plan[k][1] = s1; m_plan[k][2] = s2;
    m_len[k] = n; m_pi[k] = 0;
  endfunction

  function automatic int plan_next(input int k);
    int s;
    if (m_pi[k] >= m_len[k]) return FETCH;
    s = m_plan[k][m_pi[k]];
    m_pi[k]++;
    return s;
  endfunction

  function automatic int decode(input int k);
    bit alu_ok;
    alu_ok = (funct3[k] == 3'b000) || (funct3[k] == 3'b010) || (funct3[k] == 3'b110) ||
             (funct3[k] == 3'b111);
    set_plan(k, 0, 0, 0, 0);
    if (opcode[k] == OP_LOAD)                  set_plan(k, 3, MEMADR, MEMREAD, MEMWB);
    else if (opcode[k] == OP_STORE)            set_plan(k, 2, MEMADR, MEMWRITE, 0);
    else if (opcode[k] == OP_R && alu_ok)      set_plan(k, 2, EXEC_R, ALUWB, 0);
    else if (opcode[k] == OP_I && alu_ok)      set_plan(k, 2, EXEC_I, ALUWB, 0);
    else if (opcode[k] == OP_JAL)              set_plan(k, 2, JAL, ALUWB, 0);
    else if (opcode[k] == OP_BR && (funct3[k] == 3'b000 || (has_blt(k) && funct3[k] == 3'b100)))
      set_plan(k, 1, BRANCH, 0, 0);
    if (m_len[k] == 0) begin
      m_cause[k] = 1;
      return TRAP;
    end
    return plan_next(k);
  endfunction

  task automatic advance(input int k);
    int nx;
    nx = m_st[k];
    if (!areset[k]) begin
      case (m_st[k])
        FETCH, MEMREAD, MEMWRITE: begin
          if (mem_ready[k]) nx = (m_st[k] == FETCH) ? DECODE : plan_next(k);
          else if (m_wait[k] + 1 == tmo(k)) begin nx = TRAP; m_cause[k] = 2; end
          else m_wait[k]++;
        end
        DECODE:  nx = decode(k);
        TRAP:    m_tc[k]++;
        default: nx = plan_next(k);
      endcase
      if (nx != m_st[k]) m_wait[k] = 0;
      m_st[k] = nx;
    end
  endtask

  task automatic pick_instr(input int k);
    int c;
    c = $urandom_range(0, 11);
    funct7b5[k] = 1'($urandom_range(0, 1));
    funct3[k]   = 3'($urandom_range(0, 7));
    case (c)
      0, 1: opcode[k] = OP_LOAD;
      2:    opcode[k] = OP_STORE;
      3:    begin opcode[k] = OP_R; funct3[k] = (funct3[k][0]) ? 3'b000 : {funct3[k][1], 1'b1, funct3[k][1]}; end
      4:    begin opcode[k] = OP_I; funct3[k] = (funct3[k][0]) ? 3'b000 : {funct3[k][1], 1'b1, funct3[k][1]}; end
      5:    begin opcode[k] = OP_BR; funct3[k] = 3'b000; end
      6:    begin opcode[k] = OP_BR; funct3[k] = 3'b100; end
      7:    opcode[k] = OP_JAL;
      8:    opcode[k] = OP_R;
      9:    opcode[k] = OP_I;
      10:   opcode[k] = OP_BR;
      default: opcode[k] = 7'($urandom_range(0, 127));
    endcase
  endtask

  task automatic drive(input int k);
    bit rst;
    rst = (cyc < 2) || ($urandom_range(0, 149) == 0) || (m_st[k] == TRAP && m_tc[k] >= 20);
    areset[k] = rst;
    if (rst) begin
      m_st[k] = FETCH; m_wait[k] = 0; m_cause[k] = 0; m_tc[k] = 0;
    end
    if (m_st[k] == FETCH) pick_instr(k);
    zero[k] = 1'($urandom_range(0, 1));
    sign[k] = 1'($urandom_range(0, 1));
    if (stuck[k] > 0) begin
      stuck[k]--;
      mem_ready[k] = 1'b0;
    end else if ($urandom_range(0, 19) == 0) begin
      stuck[k] = $urandom_range(2, 20);
      mem_ready[k] = 1'b0;
    end else begin
      mem_ready[k] = ($urandom_range(0, 3) != 0);
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      areset[k] = 1'b1; opcode[k] = '0; funct3[k] = '0; funct7b5[k] = 1'b0;
      zero[k] = 1'b0; sign[k] = 1'b0; mem_ready[k] = 1'b0;
      m_st[k] = FETCH; m_wait[k] = 0; m_cause[k] = 0; m_tc[k] = 0; stuck[k] = 0;
      set_plan(k, 0, 0, 0, 0);
    end
    repeat (NCYC) begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) drive(k);
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        check($sformatf("ctl%0d cyc%0d st%0d rst%0d", k, cyc, m_st[k], areset[k]),
              {8'h00, (k == 0) ? obs0 : obs1}, {8'h00, expect_ctl(k)});
        advance(k);
      end
      cyc++;
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rv_multicycle_ctrl.md
Name: rv_multicycle_ctrl

Overview:
- Control FSM for the next-generation multi-cycle RV32I core.
- Replaces the single-cycle combinational decoder. Sequences fetch, decode, execute, memory and writeback over several clocks.
- Talks to a single unified instruction/data memory through a req/ready handshake.
- Adds optional BLT support, a memory-wait timeout, and a sticky trap on illegal instructions.

Parameters:
- HAS_BLT, 1, when 1 decode accepts funct3=100 branches (taken if sign=1); when 0 they trap.
- WAIT_TIMEOUT, 16, maximum cycles spent in any memory state without mem_ready before a trap; 0 disables the timeout.
- STATE_W, 4, width of the state debug output.

Ports:
- clk  in  1  clock
- areset  in  1  asynchronous active-high reset
- opcode  in  7  instruction register bits [6:0]
- funct3  in  3  instruction register bits [14:12]
- funct7b5  in  1  instruction register bit 30
- zero  in  1  ALU zero flag
- sign  in  1  ALU sign flag
- mem_ready  in  1  memory completes the current request this cycle
- mem_req  out  1  memory request valid
- mem_write  out  1  request is a store
- adr_src  out  1  memory address select: 0=PC, 1=ALUOut
- ir_write  out  1  latch instruction and OldPC
- pc_write  out  1  PC load enable
- reg_write  out  1  register file write enable
- alu_src_a  out  2  ALU A select: 00=PC, 01=OldPC, 10=A register
- alu_src_b  out  2  ALU B select: 00=B register, 01=ImmExt, 10=constant 4
- result_src  out  2  result select: 00=ALUOut, 01=read data, 10=ALU result
- imm_src  out  2  immediate type: 00=I, 01=S, 10=B, 11=J
- alu_control  out  3  ALU operation: 000=add, 001=sub, 010=and, 011=or, 101=slt
- trap  out  1  sticky fault flag
- trap_cause  out  2  fault cause: 00=none, 01=illegal instruction, 10=memory timeout
- state  out  STATE_W  current state encoding, for debug

Behaviour:
- Reset (async): state=FETCH, wait counter=0, trap=0, trap_cause=00.
- While areset is high, mem_req, mem_write, ir_write, pc_write and reg_write are forced to 0.
- Outputs are combinational from state plus inputs. Any output not listed for a state is 0.
- FETCH:
  - Outputs: mem_req=1, adr_src=0, a=00, b=10, add, result_src=10.
  - When mem_ready=1: ir_write=1 and pc_write=1 in the same cycle, then go to DECODE. Otherwise stay in FETCH.
- DECODE:
  - Outputs: a=01, b=01, imm_src=10, add (computes the branch target into ALUOut).
  - Next state by opcode:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXEC_R
    - 0010011 -> EXEC_I
    - 1100011 -> BRANCH
    - 1101111 -> JAL
  - Any other opcode -> TRAP with cause 01.
  - funct3 outside {000,010,110,111} for R/I types -> TRAP with cause 01.
  - Branch funct3 other than 000, or other than 100 when HAS_BLT=1 -> TRAP with cause 01.
- MEMADR:
  - Outputs: a=10, b=01, add; imm_src=00 for load, 01 for store.
  - Next: MEMREAD for a load, MEMWRITE for a store.
- MEMREAD: mem_req=1, adr_src=1. On mem_ready go to MEMWB.
- MEMWB: result_src=01, reg_write=1. Next: FETCH.
- MEMWRITE: mem_req=1, mem_write=1, adr_src=1. On mem_ready go to FETCH.
- EXEC_R: a=10, b=00. Next: ALUWB.
- EXEC_I: a=10, b=01, imm_src=00. Next: ALUWB.
- alu_control mapping for EXEC_R and EXEC_I:
  - funct3 000 -> add; sub only in EXEC_R with funct7b5=1
  - funct3 010 -> slt
  - funct3 110 -> or
  - funct3 111 -> and
- ALUWB: result_src=00, reg_write=1. Next: FETCH.
- BRANCH:
  - Outputs: a=10, b=00, sub, result_src=00.
  - pc_write = (funct3==000 & zero) | (HAS_BLT & funct3==100 & sign).
  - Next: FETCH.
- JAL:
  - Outputs: a=01, b=10, add, result_src=00, pc_write=1.
  - Next: ALUWB, which writes OldPC+4 to rd.
- TRAP:
  - trap=1 and trap_cause holds its value; all enables are 0 and mem_req=0.
  - Left only by reset.
- Wait counter:
  - Cleared on entry to FETCH, MEMREAD or MEMWRITE.
  - Increments each cycle in those states while mem_ready=0, saturating at WAIT_TIMEOUT.
  - If the counter equals WAIT_TIMEOUT-1 and mem_ready=0, go to TRAP with cause 10 (only when WAIT_TIMEOUT>0).
  - If mem_ready=1 in the timeout cycle, ready wins and there is no trap.
- mem_ready in non-memory states is ignored.
- Reset mid-operation (any state, including mid-handshake) returns to FETCH with counter and trap cleared.
- Instruction latency with zero-wait memory:
  - R/I: 4 cycles
  - lw: 5 cycles
  - sw: 4 cycles
  - branch: 3 cycles
  - jal: 4 cycles

Test Plan:
- Reset, then R-type add (opcode 0110011, funct3 000, funct7b5 0), mem_ready=1 every cycle -> states FETCH, DECODE, EXEC_R, ALUWB, FETCH; reg_write=1 only in the ALUWB cycle; funct7b5=1 gives alu_control=001.
- lw with mem_ready delayed 3 cycles in MEMREAD -> mem_req=1 and adr_src=1 held for 4 cycles; MEMWB has result_src=01 and reg_write=1; no trap.
- beq with zero=1 -> pc_write=1 in BRANCH. Repeat with zero=0 -> pc_write=0. With HAS_BLT=0, funct3=100 -> trap=1, trap_cause=01 after DECODE.
- Opcode 1111111 -> TRAP; no enable is asserted for 20 cycles; reset returns to FETCH with trap=0.
- WAIT_TIMEOUT=4 and mem_ready stuck 0 in FETCH -> TRAP with cause 10 after exactly 4 cycles in FETCH. Raising mem_ready on the 4th cycle -> DECODE, no trap.
- jal -> pc_write=1 in JAL, then reg_write=1 with result_src=00 in ALUWB. Asserting areset mid-JAL -> state=FETCH immediately and pc_write is forced to 0.
